// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory SRAM-like interface.
// One request per cycle under an addr_ok handshake, byte-lane writes, and
// in-order data_ok responses a fixed LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [ADDR_W-1:0]  wordIdx;
    logic               accept;
    logic               leaving;
    logic [CNT_W-1:0]   outstanding;
    logic [LATENCY-1:0] validPipe;   // bit 0 is stage 1, bit LATENCY-1 drives data_ok
    logic [LATENCY-1:0] readPipe;
    logic [31:0]        ramQ;        // registered RAM read, acts as stage-1 data
    logic [31:0]        lastData;

    // Byte offset and upper address bits are deliberately discarded (aliasing).
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign wordIdx = addr[ADDR_W+1:2];
    assign addr_ok = ~rst && (outstanding < CNT_W'(MAX_OUT));
    assign accept  = req && addr_ok;

    // One narrow RAM per byte lane so each strobe maps onto its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneMem [0:DEPTH-1];
            logic [7:0] laneQ;

            // Lane write on accepted write with its strobe; read port always registered.
            always_ff @(posedge clk) begin
                if (accept && wr && wstrb[gi]) begin
                    laneMem[wordIdx] <= wdata[8*gi +: 8];
                end
                laneQ <= laneMem[wordIdx];
            end

            assign ramQ[8*gi +: 8] = laneQ;
        end
    endgenerate

    // Valid / read-type shift register; cleared by reset so in-flight responses vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe <= '0;
            readPipe  <= '0;
        end else begin
            validPipe[0] <= accept;
            readPipe[0]  <= accept && !wr;
            for (int i = 1; i < LATENCY; i++) begin
                validPipe[i] <= validPipe[i-1];
                readPipe[i]  <= readPipe[i-1];
            end
        end
    end

    // Read data follows the valid bits; stages beyond the RAM register need no reset
    // because rdata is gated by the valid bit.
    generate
        if (LATENCY == 1) begin : gNoTail
            assign lastData = ramQ;
            assign leaving  = accept;
        end else begin : gTail
            logic [31:0] tail [2:LATENCY];

            // Shift the captured read word toward the output stage.
            always_ff @(posedge clk) begin
                tail[2] <= ramQ;
                for (int i = 3; i <= LATENCY; i++) begin
                    tail[i] <= tail[i-1];
                end
            end

            assign lastData = tail[LATENCY];
            // A request stops counting at the edge that opens its data_ok cycle,
            // so the freed slot can be re-used in that same cycle.
            assign leaving  = validPipe[LATENCY-2];
        end
    endgenerate

    // Outstanding-request counter; simultaneous enter and leave cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (accept && !leaving) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && leaving) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    assign data_ok = validPipe[LATENCY-1];
    assign rdata   = (validPipe[LATENCY-1] && readPipe[LATENCY-1]) ? lastData : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: instance A (LATENCY=2, MAX_OUT=2) and
// instance B (LATENCY=4, MAX_OUT=2). Inputs change and outputs are sampled on
// the falling edge.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int miscompares = 0;

    logic        rstA = 1'b1, reqA = 1'b0, wrA = 1'b0;
    logic [3:0]  wstrbA = 4'h0;
    logic [31:0] addrA = 32'h0, wdataA = 32'h0;
    logic        addrOkA, dataOkA;
    logic [31:0] rdataA;

    logic        rstB = 1'b1, reqB = 1'b0, wrB = 1'b0;
    logic [3:0]  wstrbB = 4'h0;
    logic [31:0] addrB = 32'h0, wdataB = 32'h0;
    logic        addrOkB, dataOkB;
    logic [31:0] rdataB;

    dmem_responder #(.ADDR_W(10), .LATENCY(2), .MAX_OUT(2)) dutA (
        .clk(clk), .rst(rstA), .req(reqA), .wr(wrA), .wstrb(wstrbA),
        .addr(addrA), .wdata(wdataA), .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(4), .MAX_OUT(2)) dutB (
        .clk(clk), .rst(rstB), .req(reqB), .wr(wrB), .wstrb(wstrbB),
        .addr(addrB), .wdata(wdataB), .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB)
    );

    task automatic driveA(input logic r, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reqA = r; wrA = w; wstrbA = s; addrA = a; wdataA = d;
    endtask

    task automatic driveB(input logic r, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reqB = r; wrB = w; wstrbB = s; addrB = a; wdataB = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vecs++;
        if ({addrOkA, dataOkA, rdataA} !== 34'h0) begin
            $display("FAIL reset_held_A: addr_ok=%b data_ok=%b rdata=%h want 0 0 0", addrOkA, dataOkA, rdataA);
            miscompares++;
        end
        vecs++;
        if (addrOkB !== 1'b0) begin
            $display("FAIL reset_held_B_addr_ok: got %b want 0", addrOkB);
            miscompares++;
        end
        @(negedge clk);
        rstA = 1'b0; rstB = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vecs++;
            if ({addrOkA, dataOkA, rdataA} !== {1'b1, 1'b0, 32'h0}) begin
                $display("FAIL idle_A cycle %0d: addr_ok=%b data_ok=%b rdata=%h want 1 0 0", i, addrOkA, dataOkA, rdataA);
                miscompares++;
            end
        end
        vecs++;
        if ({addrOkB, dataOkB} !== 2'b10) begin
            $display("FAIL idle_B: addr_ok=%b data_ok=%b want 1 0", addrOkB, dataOkB);
            miscompares++;
        end
    endtask

    task automatic test_write_read();
        driveA(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
        vecs++;
        if (dataOkA !== 1'b0) begin
            $display("FAIL wr_rd_c0_data_ok: got %b want 0", dataOkA); miscompares++;
        end
        driveA(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        vecs++;
        if ({addrOkA, dataOkA} !== 2'b10) begin
            $display("FAIL wr_rd_c1: addr_ok=%b data_ok=%b want 1 0", addrOkA, dataOkA); miscompares++;
        end
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h0}) begin
            $display("FAIL wr_rd_write_resp: data_ok=%b rdata=%h want 1 00000000", dataOkA, rdataA); miscompares++;
        end
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'hDEADBEEF}) begin
            $display("FAIL wr_rd_read_resp: data_ok=%b rdata=%h want 1 deadbeef", dataOkA, rdataA); miscompares++;
        end
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b0, 32'h0}) begin
            $display("FAIL wr_rd_after: data_ok=%b rdata=%h want 0 00000000", dataOkA, rdataA); miscompares++;
        end
    endtask

    task automatic test_byte_strobes();
        driveA(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
        driveA(1'b1, 1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA);
        driveA(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h0}) begin
            $display("FAIL strb_w1_resp: data_ok=%b rdata=%h want 1 00000000", dataOkA, rdataA); miscompares++;
        end
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h0}) begin
            $display("FAIL strb_w2_resp: data_ok=%b rdata=%h want 1 00000000", dataOkA, rdataA); miscompares++;
        end
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h11AA3344}) begin
            $display("FAIL strb_lane2: data_ok=%b rdata=%h want 1 11aa3344", dataOkA, rdataA); miscompares++;
        end
        driveA(1'b1, 1'b1, 4'b0001, 32'h20, 32'h55555555);
        vecs++;
        if (dataOkA !== 1'b0) begin
            $display("FAIL strb_gap_data_ok: got %b want 0", dataOkA); miscompares++;
        end
        driveA(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h11AA3355}) begin
            $display("FAIL strb_lane0: data_ok=%b rdata=%h want 1 11aa3355", dataOkA, rdataA); miscompares++;
        end
    endtask

    task automatic test_alias();
        driveA(1'b1, 1'b1, 4'hF, 32'h0000_1004, 32'h12345678);
        driveA(1'b1, 1'b0, 4'h0, 32'h0000_0006, 32'h0);
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkA, rdataA} !== {1'b1, 32'h12345678}) begin
            $display("FAIL alias_read: data_ok=%b rdata=%h want 1 12345678", dataOkA, rdataA); miscompares++;
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] bpWords [4];
        int expAok [11];
        int expDok [11];
        int issued;
        int resp;
        int pulses;
        bpWords = '{32'hA5A5_0100, 32'h5A5A_0104, 32'h0F0F_0108, 32'hF0F0_010C};
        expAok  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1};
        expDok  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            driveB(1'b1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), bpWords[i]);
            driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            repeat (5) @(negedge clk);
        end
        issued = 0; resp = 0; pulses = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (issued < 4) begin
                reqB = 1'b1; wrB = 1'b0; wstrbB = 4'h0; addrB = 32'h100 + 32'(4 * issued);
            end else begin
                reqB = 1'b0;
            end
            vecs++;
            if (addrOkB !== expAok[c][0]) begin
                $display("FAIL bp_addr_ok cycle %0d: got %b want %0d", c, addrOkB, expAok[c]); miscompares++;
            end
            vecs++;
            if (dataOkB !== expDok[c][0]) begin
                $display("FAIL bp_data_ok cycle %0d: got %b want %0d", c, dataOkB, expDok[c]); miscompares++;
            end
            if (expDok[c] == 1) begin
                vecs++;
                if (rdataB !== bpWords[resp]) begin
                    $display("FAIL bp_rdata resp %0d: got %h want %h", resp, rdataB, bpWords[resp]); miscompares++;
                end
                resp++;
            end
            if (dataOkB === 1'b1) pulses++;
            if (reqB && addrOkB === 1'b1) issued++;
        end
        reqB = 1'b0;
        vecs++;
        if (pulses != 4 || issued != 4) begin
            $display("FAIL bp_totals: pulses=%0d accepts=%0d want 4 4", pulses, issued); miscompares++;
        end
    endtask

    task automatic test_reset_midflight();
        driveB(1'b1, 1'b1, 4'hF, 32'h40, 32'h0000CAFE);
        driveB(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        vecs++;
        if (addrOkB !== 1'b1) begin
            $display("FAIL mid_second_accept: addr_ok=%b want 1", addrOkB); miscompares++;
        end
        driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2 rstB = 1'b1;
        #1;
        vecs++;
        if ({addrOkB, dataOkB, rdataB} !== 34'h0) begin
            $display("FAIL mid_rst_now: addr_ok=%b data_ok=%b rdata=%h want 0 0 0", addrOkB, dataOkB, rdataB); miscompares++;
        end
        repeat (2) @(negedge clk);
        rstB = 1'b0;
        #1;
        vecs++;
        if (addrOkB !== 1'b1) begin
            $display("FAIL mid_release_addr_ok: got %b want 1", addrOkB); miscompares++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vecs++;
            if (dataOkB !== 1'b0) begin
                $display("FAIL mid_no_resp cycle %0d: data_ok=%b want 0", i, dataOkB); miscompares++;
            end
        end
        driveB(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        for (int i = 1; i < 4; i++) begin
            driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            vecs++;
            if (dataOkB !== 1'b0) begin
                $display("FAIL mid_read_early cycle %0d: data_ok=%b want 0", i, dataOkB); miscompares++;
            end
        end
        driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        vecs++;
        if ({dataOkB, rdataB} !== {1'b1, 32'h0000CAFE}) begin
            $display("FAIL mid_ram_kept: data_ok=%b rdata=%h want 1 0000cafe", dataOkB, rdataB); miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_alias();
        test_back_pressure();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory SRAM-like interface. The datapath's M stage drives it as the initiator with address, byte-enable write strobe and write data, and expects read data back.
- Holds a word-addressed data RAM and accepts one request per cycle under an addr_ok handshake.
- Returns one data_ok pulse per accepted request, in order, a fixed LATENCY cycles after acceptance.
- The number of in-flight requests is bounded by MAX_OUT.

Parameters:
- ADDR_W, 10: word-index width; RAM depth is 2^ADDR_W words of 32 bits.
- LATENCY, 2: cycles from the acceptance edge to the data_ok cycle; legal range 1..8.
- MAX_OUT, 2: maximum accepted-but-unanswered requests; legal range 1..LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read; sampled with req
- wstrb  in  4  byte enables for a write; bit i enables byte lane i (bits 8i+7..8i); ignored for reads
- addr  in  32  byte address; bits [ADDR_W+1:2] index the RAM; bits [1:0] and the upper bits are ignored (aliasing)
- wdata  in  32  write data, already lane-replicated by the initiator
- addr_ok  out  1  request accepted this cycle when req && addr_ok
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read data, valid while data_ok is high

Behaviour:
- Reset is asynchronous active-high. While rst is high and after release:
  - outstanding count = 0
  - all pipeline stages invalid
  - data_ok = 0, rdata = 0
  - addr_ok = 1 once rst is low
  - RAM contents are not reset.
- addr_ok (combinational) = ~rst && (outstanding < MAX_OUT). It does not depend on req.
- Acceptance = req && addr_ok at a rising edge.
  - Write: at the same edge, each byte lane i with wstrb[i]=1 is written from wdata[8i+7:8i]. Lanes with wstrb[i]=0 are unchanged. wstrb=0 is legal: it is a no-op write that still gets a response.
  - Read: at the same edge, the addressed word is captured into pipeline stage 1. The captured value reflects all writes accepted on earlier edges.
- Response pipeline:
  - LATENCY stages, each holding {valid, is_read, data}, shifting one stage per cycle unconditionally.
  - Stage 1 is loaded with valid = acceptance at every edge.
  - data_ok = last-stage valid. A request accepted at edge N gives data_ok high in the cycle following edge N+LATENCY-1. With LATENCY=1, data_ok is high in the cycle right after the accepting edge.
  - rdata = last-stage data if valid && is_read, else 0. Write responses return rdata = 0.
- Outstanding counter:
  - Increments on acceptance and decrements on the data_ok cycle's edge.
  - If both happen on the same edge, it is unchanged.
  - It never exceeds MAX_OUT and never underflows.
- Ordering: responses come strictly in acceptance order; at most one data_ok per cycle.
- Back-to-back throughput:
  - MAX_OUT = LATENCY allows one accept per cycle.
  - MAX_OUT < LATENCY stalls addr_ok low once MAX_OUT requests are in flight. addr_ok goes high again in the cycle where the oldest data_ok is high.
- Same-word read following a write accepted on the previous edge returns the written data (no hazard).
- Reset asserted mid-operation:
  - All in-flight responses are discarded; no data_ok for them after release.
  - Writes already accepted remain in RAM.
- req while addr_ok = 0: no state change. The initiator holds the request until accepted.
- Out-of-range upper address bits alias onto the RAM; no error is signalled.

Test Plan:
- Reset then idle, LATENCY=2, MAX_OUT=2:
  - expect addr_ok=1, data_ok=0, rdata=0 for 10 cycles.
- Write then read:
  - stimulus: write addr 0x0000_0010, wstrb 4'b1111, wdata 0xDEADBEEF; then read 0x10 on the next cycle.
  - expect data_ok for the write 2 cycles after its accept with rdata=0.
  - expect data_ok for the read the following cycle with rdata=0xDEADBEEF.
- Byte strobes:
  - stimulus: write 0x11223344 to 0x20; then write 0xAAAAAAAA with wstrb 4'b0100; then read 0x20.
  - expect rdata 0x11AA3344.
  - stimulus: sb-style wdata 0x55555555 with wstrb 4'b0001, then read.
  - expect rdata 0x11AA3355.
- Back-pressure, LATENCY=4, MAX_OUT=2:
  - stimulus: req held high with 4 reads.
  - expect addr_ok low after 2 accepts, high again in the first data_ok cycle.
  - expect exactly 4 data_ok pulses, in order, matching the preloaded words.
- Reset mid-flight:
  - stimulus: accept write 0x0000CAFE to 0x40 and a read of 0x44, then assert rst asynchronously between edges before any data_ok.
  - expect data_ok=0 immediately and for 6 cycles after release.
  - a later read of 0x40 returns 0x0000CAFE.
- Aliasing and alignment:
  - stimulus: write 0x12345678 to 0x0000_1004 with ADDR_W=10; then read 0x0000_0006.
  - expect rdata 0x12345678.
